// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - decode register scoreboard, hazard stall and watchdog; optional SCOREBOARD_WB_BYPASS_EN
module decode_scoreboard #(
    parameter int STALL_MAX = 64,
    parameter int CNT_W     = 7
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DE_V,
    input  logic [31:0] DE_IR,
    input  logic        WB_V,
    input  logic [4:0]  WB_RD,
    input  logic        FLUSH,
    output logic        DE_STALL,
    output logic        DE_ISSUE,
    output logic [31:0] BUSY_MASK,
    output logic [5:0]  PEND_CNT,
    output logic        HANG
);

    logic [6:0]       op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic             wr_rd;
    logic [31:0]      wb_mask;
    logic [31:0]      busy_eff;
    logic             hazard;
    logic             do_set;
    logic             do_clr;
    logic [31:0]      busy_next;
    logic [5:0]       pend_next;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             unused_ir;

    assign op  = DE_IR[6:0];
    assign rd  = DE_IR[11:7];
    assign rs1 = DE_IR[19:15];
    assign rs2 = DE_IR[24:20];

    // funct3/funct7 do not affect register usage
    assign unused_ir = ^{DE_IR[31:25], DE_IR[14:12]};

    // Opcode class: which source fields are read and whether rd is written
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_rd   = 1'b0;
        case (op)
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_rd   = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                use_rs1 = 1'b1;
                wr_rd   = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                wr_rd   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign wb_mask = WB_V ? (32'd1 << WB_RD) : 32'd0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    // A same-cycle writeback already satisfies the dependency (write-through regfile)
    assign busy_eff = BUSY_MASK & ~wb_mask;
`else
    assign busy_eff = BUSY_MASK;
`endif

    assign hazard = (use_rs1 & busy_eff[rs1])
                  | (use_rs2 & busy_eff[rs2])
                  | (wr_rd & (rd != 5'd0) & busy_eff[rd]);

    assign DE_STALL = DE_V &  hazard & ~FLUSH;
    assign DE_ISSUE = DE_V & ~hazard & ~FLUSH;

    // Set is applied after clear so a same-register set/clear leaves the bit set
    always_comb begin
        do_set    = DE_ISSUE & wr_rd & (rd != 5'd0);
        do_clr    = WB_V & BUSY_MASK[WB_RD];
        busy_next = BUSY_MASK;
        if (do_clr) begin
            busy_next = busy_next & ~wb_mask;
        end
        if (do_set) begin
            busy_next = busy_next | (32'd1 << rd);
        end
        busy_next[0] = 1'b0;
        pend_next    = PEND_CNT + {5'd0, do_set} - {5'd0, do_clr};
    end

    // Consecutive-stall counter, saturating at STALL_MAX
    always_comb begin
        cnt_next = '0;
        if (DE_STALL) begin
            if (stall_cnt >= CNT_W'(STALL_MAX)) begin
                cnt_next = stall_cnt;
            end else begin
                cnt_next = stall_cnt + CNT_W'(1);
            end
        end
    end

    // Scoreboard state, pending count and watchdog flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUSY_MASK <= '0;
            PEND_CNT  <= '0;
            stall_cnt <= '0;
            HANG      <= 1'b0;
        end else begin
            BUSY_MASK <= busy_next;
            PEND_CNT  <= pend_next;
            stall_cnt <= cnt_next;
            HANG      <= (cnt_next == CNT_W'(STALL_MAX));
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// tb/tb_decode_scoreboard.sv - self-checking bench for decode_scoreboard
module tb_decode_scoreboard;

    localparam int STALL_MAX = 64;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        DE_V = 1'b0;
    logic [31:0] DE_IR = 32'd0;
    logic        WB_V = 1'b0;
    logic [4:0]  WB_RD = 5'd0;
    logic        FLUSH = 1'b0;
    logic        DE_STALL;
    logic        DE_ISSUE;
    logic [31:0] BUSY_MASK;
    logic [5:0]  PEND_CNT;
    logic        HANG;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [31:0] busy_m = 32'd0;
    int          stall_run = 0;

    decode_scoreboard #(.STALL_MAX(STALL_MAX), .CNT_W(7)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .DE_V      (DE_V),
        .DE_IR     (DE_IR),
        .WB_V      (WB_V),
        .WB_RD     (WB_RD),
        .FLUSH     (FLUSH),
        .DE_STALL  (DE_STALL),
        .DE_ISSUE  (DE_ISSUE),
        .BUSY_MASK (BUSY_MASK),
        .PEND_CNT  (PEND_CNT),
        .HANG      (HANG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads_two(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit reads_one(input logic [6:0] op);
        return op inside {7'b0010011, 7'b0000011, 7'b1100111};
    endfunction

    function automatic bit writes(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                          7'b1101111, 7'b0110111, 7'b0010111};
    endfunction

    function automatic bit m_hazard(input logic [31:0] ir, input logic [31:0] busy,
                                    input bit wbv, input logic [4:0] wbrd);
        logic [31:0] b;
        logic [6:0]  op;
        b  = busy;
        op = ir[6:0];
        if (BYPASS && wbv) b[wbrd] = 1'b0;
        b[0] = 1'b0;
        return ((reads_two(op) || reads_one(op)) && b[ir[19:15]])
            || (reads_two(op) && b[ir[24:20]])
            || (writes(op) && ir[11:7] != 5'd0 && b[ir[11:7]]);
    endfunction

    // Reference model: set of busy registers and length of the current stall run
    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                busy_m    = 32'd0;
                stall_run = 0;
            end else begin
                logic [31:0] nb;
                bit hz, st, is;
                hz = m_hazard(DE_IR, busy_m, WB_V, WB_RD);
                st = DE_V && hz && !FLUSH;
                is = DE_V && !hz && !FLUSH;
                nb = busy_m;
                if (WB_V && nb[WB_RD]) nb[WB_RD] = 1'b0;
                if (is && writes(DE_IR[6:0]) && DE_IR[11:7] != 5'd0) nb[DE_IR[11:7]] = 1'b1;
                busy_m    = nb;
                stall_run = st ? stall_run + 1 : 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (check_en) begin
            bit hz;
            hz = m_hazard(DE_IR, busy_m, WB_V, WB_RD);
            chk("model_stall", {31'd0, DE_STALL}, {31'd0, DE_V && hz && !FLUSH});
            chk("model_issue", {31'd0, DE_ISSUE}, {31'd0, DE_V && !hz && !FLUSH});
            chk("model_busy", BUSY_MASK, busy_m);
            chk("model_pend", {26'd0, PEND_CNT}, $countones(busy_m));
            chk("model_hang", {31'd0, HANG}, {31'd0, stall_run >= STALL_MAX});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", BUSY_MASK, 32'h0);
        chk("rst_pend", {26'd0, PEND_CNT}, 32'd0);
        chk("rst_hang", {31'd0, HANG}, 32'd0);
        chk("rst_stall", {31'd0, DE_STALL}, 32'd0);
        RST_N    = 1'b1;
        check_en = 1'b1;
        step();

        // addi x1,x2,5
        DE_V = 1'b1; DE_IR = 32'h00510093;
        #1 chk("addi_issue", {31'd0, DE_ISSUE}, 32'd1);
        step();
        // add x3,x1,x1 depends on x1
        DE_IR = 32'h001081B3;
        chk("addi_busy", BUSY_MASK, 32'h00000002);
        chk("addi_pend", {26'd0, PEND_CNT}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("raw_stall", {31'd0, DE_STALL}, 32'd1);
            step();
        end
        WB_V = 1'b1; WB_RD = 5'd1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        #1 chk("wb_bypass_issue", {31'd0, DE_ISSUE}, 32'd1);
        step();
        WB_V = 1'b0; DE_V = 1'b0;
`else
        #1 chk("wb_cycle_stall", {31'd0, DE_STALL}, 32'd1);
        step();
        WB_V = 1'b0;
        chk("after_wb_busy", BUSY_MASK, 32'h0);
        chk("after_wb_issue", {31'd0, DE_ISSUE}, 32'd1);
        step();
        DE_V = 1'b0;
`endif
        chk("add_busy", BUSY_MASK, 32'h00000008);
        chk("add_pend", {26'd0, PEND_CNT}, 32'd1);
        WB_V = 1'b1; WB_RD = 5'd3;
        step();
        WB_V = 1'b0;
        chk("x3_cleared", BUSY_MASK, 32'h0);

        // addi x0,x0,5 is never tracked; WB to x0 ignored
        DE_V = 1'b1; DE_IR = 32'h00500013;
        #1 chk("x0_issue", {31'd0, DE_ISSUE}, 32'd1);
        step();
        DE_V = 1'b0;
        chk("x0_busy", BUSY_MASK, 32'h0);
        chk("x0_pend", {26'd0, PEND_CNT}, 32'd0);
        WB_V = 1'b1; WB_RD = 5'd0;
        step();
        WB_V = 1'b0;
        chk("wb0_busy", BUSY_MASK, 32'h0);

        // addi x6,x0,1 makes x6 busy
        DE_V = 1'b1; DE_IR = 32'h00100313;
        step();
        DE_IR = 32'h0063A423;
        chk("x6_busy", BUSY_MASK, 32'h00000040);
        chk("sw_raw_stall", {31'd0, DE_STALL}, 32'd1);
        step();
        DE_IR = 32'h00001337;
        chk("lui_waw_stall", {31'd0, DE_STALL}, 32'd1);
        FLUSH = 1'b1;
        #1 chk("flush_stall", {31'd0, DE_STALL}, 32'd0);
        chk("flush_issue", {31'd0, DE_ISSUE}, 32'd0);
        step();
        FLUSH = 1'b0;
        chk("flush_busy", BUSY_MASK, 32'h00000040);

        // watchdog: lui x6 held stalled
        repeat (63) step();
        chk("hang_63", {31'd0, HANG}, 32'd0);
        step();
        chk("hang_64", {31'd0, HANG}, 32'd1);
        repeat (3) step();
        chk("hang_sat", {31'd0, HANG}, 32'd1);
        WB_V = 1'b1; WB_RD = 5'd6;
`ifdef SCOREBOARD_WB_BYPASS_EN
        #1 chk("wd_bypass_issue", {31'd0, DE_ISSUE}, 32'd1);
        step();
        WB_V = 1'b0; DE_V = 1'b0;
`else
        #1 chk("wd_wb_stall", {31'd0, DE_STALL}, 32'd1);
        step();
        WB_V = 1'b0;
        chk("wd_issue", {31'd0, DE_ISSUE}, 32'd1);
        chk("wd_hang_held", {31'd0, HANG}, 32'd1);
        step();
        DE_V = 1'b0;
`endif
        chk("wd_hang_clear", {31'd0, HANG}, 32'd0);
        chk("wd_busy", BUSY_MASK, 32'h00000040);
        chk("wd_pend", {26'd0, PEND_CNT}, 32'd1);

        // build PEND_CNT=3, stall, then async reset between edges
        DE_V = 1'b1; DE_IR = 32'h00510093;
        step();
        DE_IR = 32'h00100113;
        step();
        DE_IR = 32'h001081B3;
        chk("pre_rst_busy", BUSY_MASK, 32'h00000046);
        chk("pre_rst_pend", {26'd0, PEND_CNT}, 32'd3);
        chk("pre_rst_stall", {31'd0, DE_STALL}, 32'd1);
        step();
        #1 RST_N = 1'b0;
        #1;
        chk("arst_busy", BUSY_MASK, 32'h0);
        chk("arst_pend", {26'd0, PEND_CNT}, 32'd0);
        chk("arst_hang", {31'd0, HANG}, 32'd0);
        chk("arst_stall", {31'd0, DE_STALL}, 32'd0);
        chk("arst_issue", {31'd0, DE_ISSUE}, 32'd1);
        #1 RST_N = 1'b1;
        step();
        DE_V = 1'b0;
        chk("post_rst_busy", BUSY_MASK, 32'h00000008);
        chk("post_rst_pend", {26'd0, PEND_CNT}, 32'd1);
        WB_V = 1'b1; WB_RD = 5'd3;
        step();
        WB_V = 1'b0;
        step();
        chk("final_busy", BUSY_MASK, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
Register scoreboard and stall controller for the decode stage. Tracks which architectural registers have a result in flight between issue and writeback. Asserts DE_STALL to hold the decode/issue slot on RAW or WAW hazards. Sits beside decode_stage: it consumes the same DE_V/DE_IR and the writeback-port handshake, and gates whether decode presents EX_V.

Parameters:
STALL_MAX, 64, consecutive stall cycles before HANG asserts (1..127)
CNT_W, 7, width of the internal stall counter; must hold STALL_MAX

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
DE_V  input  1  decode slot holds a valid instruction
DE_IR  input  32  instruction in decode slot
WB_V  input  1  writeback of one previously issued instruction this cycle
WB_RD  input  5  destination register being written back
FLUSH  input  1  kill the instruction in the decode slot this cycle
DE_STALL  output  1  hold decode slot (combinational)
DE_ISSUE  output  1  instruction leaves decode this cycle (combinational)
BUSY_MASK  output  32  registered busy bit per register; bit 0 always 0
PEND_CNT  output  6  registered number of set BUSY_MASK bits
HANG  output  1  registered watchdog flag

Behaviour:
- Field decode from DE_IR: op=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
- Source use: 0110011, 0100011, 1100011 use rs1 and rs2. 0010011, 0000011, 1100111 use rs1 only. 0110111, 0010111, 1101111 use no sources. Any other opcode uses no sources and writes no rd.
- rd write: 0110011, 0010011, 0000011, 1100111, 1101111, 0110111, 0010111. Writes to rd=0 are never tracked.
- hazard = (rs1 used & busy[rs1]) | (rs2 used & busy[rs2]) | (rd written & rd!=0 & busy[rd]) (WAW). A register index of 0 is never busy.
- DE_STALL = DE_V & hazard & ~FLUSH.
- DE_ISSUE = DE_V & ~hazard & ~FLUSH.
- On a clock edge:
  - If DE_ISSUE and rd is written and rd!=0, set busy[rd].
  - If WB_V and busy[WB_RD], clear busy[WB_RD].
  - If set and clear target the same register in the same cycle, the set wins.
  - WB_V to a non-busy register, or to WB_RD=0, is ignored.
- The pipeline delivers exactly one WB_V for every issued rd-writing instruction, including instructions killed downstream. FLUSH therefore never clears busy bits; it only suppresses issue of the decode-slot instruction.
- PEND_CNT updates in the same cycle as BUSY_MASK: +1 on a set, -1 on an effective clear, net 0 when both occur, and +0 when set and clear hit the same register. PEND_CNT always equals popcount(BUSY_MASK).
- Watchdog:
  - stall_cnt increments each cycle DE_STALL=1 and saturates at STALL_MAX.
  - stall_cnt resets to 0 on any cycle with DE_STALL=0.
  - HANG is registered and equals 1 when stall_cnt has reached STALL_MAX. It clears the cycle after DE_STALL drops.
- Reset (async, RST_N=0): BUSY_MASK=0, PEND_CNT=0, stall_cnt=0, HANG=0, all immediately. DE_STALL therefore goes 0 combinationally. An instruction held mid-stall issues on the first edge after RST_N releases if DE_V is still 1.
- Latency: issue to busy visible is 1 cycle. WB to busy clear is 1 cycle, unless the optional feature is enabled.

Optional Feature:
Macro SCOREBOARD_WB_BYPASS_EN.
- Defined: busy bits used in the hazard equation are masked by the same-cycle writeback, i.e. effective busy[r] = busy[r] & ~(WB_V & WB_RD==r). A dependent instruction issues in the same cycle its producer writes back, with zero extra stall. The register file must supply write-through read data for this to be correct.
- Undefined: the hazard equation uses the registered busy bits only, so the dependent issues one cycle after WB_V.
- Neither mode changes the BUSY_MASK/PEND_CNT update rules.

Test Plan:
- Reset, then DE_V=1, DE_IR=0x00510093 (addi x1,x2,5) for one cycle. Expect DE_ISSUE=1, and next cycle BUSY_MASK=0x00000002, PEND_CNT=1.
- Then DE_IR=0x001081B3 (add x3,x1,x1). Expect DE_STALL=1 every cycle until WB_V=1, WB_RD=1. With bypass undefined: issue on the cycle after WB, BUSY_MASK=0x00000008, PEND_CNT=1. With bypass defined: issue in the WB cycle.
- DE_IR=0x00500013 (addi x0,x0,5) issued. Expect BUSY_MASK stays 0 and PEND_CNT=0. A WB_V with WB_RD=0 changes nothing.
- With busy[6]=1: sw x6,8(x7) (0x0063A423) gives DE_STALL=1 (RAW on rs2). lui x6,1 (0x00001337) gives DE_STALL=1 (WAW). FLUSH=1 in the same cycle gives DE_STALL=0, DE_ISSUE=0, and BUSY_MASK unchanged.
- Hold a dependent instruction stalled with no WB, STALL_MAX=64. Expect HANG=1 after the 64th consecutive stall cycle. Then apply WB_V to the blocking register: the instruction issues and HANG=0 the following cycle.
- With PEND_CNT=3 and DE_STALL=1, pulse RST_N low between clock edges. Expect BUSY_MASK=0, PEND_CNT=0, HANG=0, and DE_STALL=0 immediately, without waiting for a clock edge.
